// File: rtl/fifo_axis_pkg.sv
// Shared widths, helpers and output-register state for the FIFO-to-AXI4-Stream packer.
package fifo_axis_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_t;

  // One extra bit so the count can hold BYTES itself (beat full).
  function automatic int lane_cnt_w(input int bytes);
    return $clog2(bytes) + 1;
  endfunction

  function automatic int beat_cnt_w(input int max_beats);
    return (max_beats > 1) ? $clog2(max_beats) : 1;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop level synchroniser into the rclk domain, async active-low reset.
module bit_sync (
  input  logic rclk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge rclk or negedge resetn) begin
    if (!resetn) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/fifo_axis_packer.sv
// Drains the byte FIFO into little-endian AXI4-Stream beats; idle timeout flushes a partial/null beat with tlast.
// Optional build macro FIFO_AXIS_PKT_LIMIT_EN forces tlast every MAX_BEATS beats; overrun latches a sticky irq.
module fifo_axis_packer
  import fifo_axis_pkg::*;
#(
  parameter int BYTES     = 4,
  parameter int MAX_BEATS = 256
) (
  input  logic                      rclk,
  input  logic                      resetn,
  output logic                      fifo_rinc,
  input  logic [BYTE_W-1:0]         fifo_rdata,
  input  logic                      fifo_rempty,
  input  logic                      fifo_tout,
  input  logic                      fifo_overrun,
  output logic [BYTE_W*BYTES-1:0]   m_axis_tdata,
  output logic [BYTES-1:0]          m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      irq_overrun,
  input  logic                      ovr_clr
);

  localparam int LW = lane_cnt_w(BYTES);
  localparam int BW = beat_cnt_w(MAX_BEATS);

  if ((BYTES < 1) || ((BYTES & (BYTES - 1)) != 0)) begin : g_bytes_chk
    $error("fifo_axis_packer: BYTES must be a power of 2");
  end

  logic                         tout_s;
  logic                         ovr_s;
  logic                         tout_q;
  logic                         ovr_q;
  logic                         run;
  logic                         rd_pend;
  logic                         flush_pend;
  logic                         edge_pend;
  logic [LW-1:0]                lane_cnt;
  logic [BW-1:0]                beat_cnt;
  logic [BYTES-1:0][BYTE_W-1:0] pack;
  out_state_t                   out_state;

  logic [LW:0]                  fill;
  logic                         tout_rise;
  logic                         ovr_rise;
  logic                         beat_open;
  logic                         out_free;
  logic                         full_close;
  logic                         flush_close;
  logic                         null_close;
  logic                         flush_idle;
  logic                         flush_arm;
  logic                         flush_done;
  logic                         close;
  logic                         limit_last;
  logic                         last_c;
  logic [BYTES-1:0]             keep_c;

  bit_sync u_tout_sync (
    .rclk   (rclk),
    .resetn (resetn),
    .d      (fifo_tout),
    .q      (tout_s)
  );

  bit_sync u_ovr_sync (
    .rclk   (rclk),
    .resetn (resetn),
    .d      (fifo_overrun),
    .q      (ovr_s)
  );

  // run keeps the read strobe low while reset is asserted and for the first cycle after it.
  assign fill      = {1'b0, lane_cnt} + {{LW{1'b0}}, rd_pend};
  assign fifo_rinc = run & ~fifo_rempty & (fill < (LW+1)'(BYTES)) & ~flush_pend;

  assign tout_rise = tout_s & ~tout_q;
  assign ovr_rise  = ovr_s & ~ovr_q;
  assign beat_open = (beat_cnt != '0);
  assign out_free  = (out_state == EMPTY) | m_axis_tready;

  // A full beat always closes first; a pending flush then sees lane_cnt==0 and emits a null beat.
  assign full_close  = (lane_cnt == LW'(BYTES));
  assign flush_close = flush_pend & ~full_close & (lane_cnt != '0);
  assign null_close  = flush_pend & ~full_close & (lane_cnt == '0) & beat_open;
  assign flush_idle  = flush_pend & ~full_close & (lane_cnt == '0) & ~beat_open;
  assign close       = out_free & (full_close | flush_close | null_close);
  assign flush_done  = flush_idle | (out_free & (flush_close | null_close));

  // The timeout edge is only acted on once the FIFO has drained and no byte is in flight.
  assign flush_arm   = (edge_pend | tout_rise) & fifo_rempty & ~rd_pend & ~flush_pend;

`ifdef FIFO_AXIS_PKT_LIMIT_EN
  assign limit_last = (beat_cnt == BW'(MAX_BEATS - 1));
`else
  assign limit_last = 1'b0;
`endif

  assign last_c = flush_close | null_close | limit_last;

  always_comb begin
    keep_c = '0;
    for (int i = 0; i < BYTES; i++) begin
      keep_c[i] = (LW'(i) < lane_cnt);
    end
  end

  assign m_axis_tvalid = (out_state == FULL);

  always_ff @(posedge rclk or negedge resetn) begin
    if (!resetn) begin
      run        <= 1'b0;
      rd_pend    <= 1'b0;
      tout_q     <= 1'b0;
      ovr_q      <= 1'b0;
      edge_pend  <= 1'b0;
      flush_pend <= 1'b0;
    end else begin
      run       <= 1'b1;
      rd_pend   <= fifo_rinc;
      tout_q    <= tout_s;
      ovr_q     <= ovr_s;
      edge_pend <= (edge_pend | tout_rise) & ~flush_arm;
      if (flush_arm) begin
        flush_pend <= 1'b1;
      end else if (flush_done) begin
        flush_pend <= 1'b0;
      end
    end
  end

  // Pack register: a close and a lane write never coincide, since reads stop before the beat fills
  // and are blocked while a flush is pending.
  always_ff @(posedge rclk or negedge resetn) begin
    if (!resetn) begin
      lane_cnt <= '0;
      pack     <= '0;
    end else if (close) begin
      lane_cnt <= '0;
      pack     <= '0;
    end else if (rd_pend) begin
      for (int i = 0; i < BYTES; i++) begin
        if (lane_cnt == LW'(i)) begin
          pack[i] <= fifo_rdata;
        end
      end
      lane_cnt <= lane_cnt + LW'(1);
    end
  end

  always_ff @(posedge rclk or negedge resetn) begin
    if (!resetn) begin
      beat_cnt <= '0;
    end else if (close) begin
      if (last_c) begin
        beat_cnt <= '0;
`ifdef FIFO_AXIS_PKT_LIMIT_EN
      end else begin
        beat_cnt <= beat_cnt + BW'(1);
      end
`else
      end else if (beat_cnt != '1) begin
        beat_cnt <= beat_cnt + BW'(1);
      end
`endif
    end
  end

  always_ff @(posedge rclk or negedge resetn) begin
    if (!resetn) begin
      out_state    <= EMPTY;
      m_axis_tdata <= '0;
      m_axis_tkeep <= '0;
      m_axis_tlast <= 1'b0;
    end else if (close) begin
      out_state    <= FULL;
      m_axis_tdata <= pack;
      m_axis_tkeep <= keep_c;
      m_axis_tlast <= last_c;
    end else if (m_axis_tready) begin
      out_state <= EMPTY;
    end
  end

  // A new overrun edge wins over a clear in the same cycle.
  always_ff @(posedge rclk or negedge resetn) begin
    if (!resetn) begin
      irq_overrun <= 1'b0;
    end else if (ovr_rise) begin
      irq_overrun <= 1'b1;
    end else if (ovr_clr) begin
      irq_overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_axis_packer.sv
// Scoreboard bench for fifo_axis_packer: byte FIFO model in front, beat monitor behind.
module tb_fifo_axis_packer;

  localparam int MAXB = 4;
`ifdef FIFO_AXIS_PKT_LIMIT_EN
  localparam bit LIMIT = 1'b1;
`else
  localparam bit LIMIT = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  k;
    logic        l;
  } beat_t;

  logic        rclk          = 1'b0;
  logic        resetn        = 1'b0;
  logic        fifo_rinc;
  logic [7:0]  fifo_rdata    = 8'h00;
  logic        fifo_rempty   = 1'b1;
  logic        fifo_tout     = 1'b0;
  logic        fifo_overrun  = 1'b0;
  logic [31:0] m_axis_tdata;
  logic [3:0]  m_axis_tkeep;
  logic        m_axis_tlast;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        irq_overrun;
  logic        ovr_clr       = 1'b0;

  logic [7:0]  byteq[$];
  beat_t       exp_q[$];
  beat_t       obs_q[$];
  int          vectors     = 0;
  int          miscompares = 0;
  int          rd_count    = 0;
  logic        acc         = 1'b0;

  fifo_axis_packer #(.BYTES(4), .MAX_BEATS(MAXB)) dut (
    .rclk          (rclk),
    .resetn        (resetn),
    .fifo_rinc     (fifo_rinc),
    .fifo_rdata    (fifo_rdata),
    .fifo_rempty   (fifo_rempty),
    .fifo_tout     (fifo_tout),
    .fifo_overrun  (fifo_overrun),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .irq_overrun   (irq_overrun),
    .ovr_clr       (ovr_clr)
  );

  always #5 rclk = ~rclk;

  // FIFO model: a read accepted at a rising edge presents its byte from the next falling edge.
  always @(negedge rclk) begin
    if (acc && byteq.size() > 0) begin
      fifo_rdata = byteq.pop_front();
      rd_count++;
    end
    fifo_rempty = (byteq.size() == 0);
    #1;
    acc = fifo_rinc & ~fifo_rempty & resetn;
  end

  always @(negedge rclk) begin
    #2;
    if (m_axis_tvalid && m_axis_tready)
      obs_q.push_back({m_axis_tdata, m_axis_tkeep, m_axis_tlast});
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge rclk);
  endtask

  task automatic collect(input int n);
    int t = 0;
    while (obs_q.size() < n && t < 400) begin
      @(negedge rclk);
      t++;
    end
    cycles(10);
  endtask

  task automatic pulse_tout();
    @(negedge rclk);
    fifo_tout = 1'b1;
    cycles(3);
    fifo_tout = 1'b0;
  endtask

  task automatic test_reset();
    beat_t e, o;
    resetn = 1'b0;
    cycles(2);
    byteq.push_back(8'hAA); byteq.push_back(8'hBB);
    byteq.push_back(8'hCC); byteq.push_back(8'hDD);
    cycles(3);
    #3;
    vectors += 6;
    if (fifo_rinc !== 1'b0) begin miscompares++; $display("FAIL reset_rinc got %b want 0", fifo_rinc); end
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL reset_tvalid got %b want 0", m_axis_tvalid); end
    if (m_axis_tdata !== 32'h0) begin miscompares++; $display("FAIL reset_tdata got %h want 0", m_axis_tdata); end
    if (m_axis_tkeep !== 4'h0) begin miscompares++; $display("FAIL reset_tkeep got %h want 0", m_axis_tkeep); end
    if (m_axis_tlast !== 1'b0) begin miscompares++; $display("FAIL reset_tlast got %b want 0", m_axis_tlast); end
    if (irq_overrun !== 1'b0) begin miscompares++; $display("FAIL reset_irq got %b want 0", irq_overrun); end
    @(negedge rclk);
    m_axis_tready = 1'b1;
    exp_q.push_back({32'hDDCCBBAA, 4'hF, 1'b0});
    resetn = 1'b1;
    collect(1);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL reset_release_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL reset_release_beat got %h/%h/%b want %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_basic();
    beat_t e, o;
    logic [7:0] b [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    exp_q.push_back({32'h44332211, 4'hF, 1'b0});
    foreach (b[i]) byteq.push_back(b[i]);
    collect(1);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL basic_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL basic_beat got %h/%h/%b want %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_tout_partial();
    beat_t e, o;
    for (int i = 1; i <= 6; i++) byteq.push_back(8'(i * 8'h11));
    exp_q.push_back({32'h44332211, 4'hF, 1'b0});
    exp_q.push_back({32'h00006655, 4'h3, 1'b1});
    cycles(15);
    pulse_tout();
    collect(2);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL tout_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL tout_beat got %h/%h/%b want %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_backpressure();
    beat_t e, o;
    int r0;
    @(negedge rclk);
    m_axis_tready = 1'b0;
    r0 = rd_count;
    for (int i = 0; i < 20; i++) byteq.push_back(8'(8'h30 + i));
    for (int k = 0; k < 5; k++)
      exp_q.push_back({8'(8'h33 + 4*k), 8'(8'h32 + 4*k), 8'(8'h31 + 4*k), 8'(8'h30 + 4*k), 4'hF, 1'b0});
    cycles(10);
    vectors++;
    if (m_axis_tdata !== 32'h33323130) begin miscompares++; $display("FAIL bp_hold_early got %h want 33323130", m_axis_tdata); end
    cycles(20);
    #3;
    vectors += 5;
    if (rd_count - r0 != 8) begin miscompares++; $display("FAIL bp_reads got %0d want 8", rd_count - r0); end
    if (fifo_rinc !== 1'b0) begin miscompares++; $display("FAIL bp_rinc got %b want 0", fifo_rinc); end
    if (m_axis_tvalid !== 1'b1) begin miscompares++; $display("FAIL bp_tvalid got %b want 1", m_axis_tvalid); end
    if (m_axis_tdata !== 32'h33323130) begin miscompares++; $display("FAIL bp_hold_late got %h want 33323130", m_axis_tdata); end
    if ({m_axis_tkeep, m_axis_tlast} !== 5'b11110) begin miscompares++; $display("FAIL bp_keep_last got %h/%b want f/0", m_axis_tkeep, m_axis_tlast); end
    @(negedge rclk);
    m_axis_tready = 1'b1;
    collect(5);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL bp_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL bp_beat got %h/%h/%b want %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_null_beat();
    beat_t e, o;
    byteq.push_back(8'hA1); byteq.push_back(8'hA2);
    byteq.push_back(8'hA3); byteq.push_back(8'hA4);
    exp_q.push_back({32'hA4A3A2A1, 4'hF, 1'b0});
    exp_q.push_back({32'h00000000, 4'h0, 1'b1});
    cycles(12);
    pulse_tout();
    collect(2);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL null_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL null_beat got %h/%h/%b want %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
    end
    exp_q.delete(); obs_q.delete();
    pulse_tout();
    cycles(15);
    vectors++;
    if (obs_q.size() != 0) begin miscompares++; $display("FAIL idle_flush got %0d beats want 0", obs_q.size()); end
    obs_q.delete();
  endtask

  task automatic test_pkt_limit();
    beat_t e, o;
    for (int i = 0; i < 32; i++) byteq.push_back(8'(8'h80 + i));
    for (int k = 0; k < 8; k++)
      exp_q.push_back({8'(8'h83 + 4*k), 8'(8'h82 + 4*k), 8'(8'h81 + 4*k), 8'(8'h80 + 4*k), 4'hF,
                       LIMIT && ((k % MAXB) == MAXB - 1)});
    collect(8);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL limit_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL limit_beat got %h/%h/%b want %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  task automatic test_overrun();
    int cnt = 0;
    @(negedge rclk);
    fifo_overrun = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge rclk);
      #1;
      cnt = i;
      if (i == 1) fifo_overrun = 1'b0;
      if (irq_overrun) break;
    end
    vectors++;
    if (!(irq_overrun === 1'b1 && cnt >= 2 && cnt <= 3)) begin
      miscompares++; $display("FAIL ovr_latency got irq=%b after %0d cycles want 1 after 2..3", irq_overrun, cnt);
    end
    cycles(5);
    vectors++;
    if (irq_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_sticky got %b want 1", irq_overrun); end
    ovr_clr = 1'b1;
    @(negedge rclk);
    ovr_clr = 1'b0;
    vectors++;
    if (irq_overrun !== 1'b0) begin miscompares++; $display("FAIL ovr_clear got %b want 0", irq_overrun); end
    cycles(3);
    fifo_overrun = 1'b1;
    @(negedge rclk);
    fifo_overrun = 1'b0;
    @(negedge rclk);
    ovr_clr = 1'b1;
    @(negedge rclk);
    ovr_clr = 1'b0;
    vectors++;
    if (irq_overrun !== 1'b1) begin miscompares++; $display("FAIL ovr_set_wins got %b want 1", irq_overrun); end
    cycles(4);
  endtask

  task automatic test_reset_mid();
    beat_t e, o;
    byteq.push_back(8'h5A); byteq.push_back(8'h5B);
    cycles(8);
    vectors++;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_no_beat got %b want 0", m_axis_tvalid); end
    resetn = 1'b0;
    #1;
    vectors += 5;
    if (m_axis_tvalid !== 1'b0) begin miscompares++; $display("FAIL mid_tvalid got %b want 0", m_axis_tvalid); end
    if (m_axis_tdata !== 32'h0) begin miscompares++; $display("FAIL mid_tdata got %h want 0", m_axis_tdata); end
    if ({m_axis_tkeep, m_axis_tlast} !== 5'b0) begin miscompares++; $display("FAIL mid_keep_last got %h/%b want 0/0", m_axis_tkeep, m_axis_tlast); end
    if (irq_overrun !== 1'b0) begin miscompares++; $display("FAIL mid_irq got %b want 0", irq_overrun); end
    if (fifo_rinc !== 1'b0) begin miscompares++; $display("FAIL mid_rinc got %b want 0", fifo_rinc); end
    cycles(2);
    resetn = 1'b1;
    obs_q.delete();
    byteq.push_back(8'hC1); byteq.push_back(8'hC2);
    byteq.push_back(8'hC3); byteq.push_back(8'hC4);
    exp_q.push_back({32'hC4C3C2C1, 4'hF, 1'b0});
    collect(1);
    vectors++;
    if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL mid_count got %0d want %0d", obs_q.size(), exp_q.size()); end
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); vectors++;
      if (o !== e) begin miscompares++; $display("FAIL mid_beat got %h/%h/%b want %h/%h/%b", o.d, o.k, o.l, e.d, e.k, e.l); end
    end
    exp_q.delete(); obs_q.delete();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_tout_partial();
    test_backpressure();
    test_null_beat();
    test_pkt_limit();
    test_overrun();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
